// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path:
//   - UART_BYTE_W          : width of one UART byte
//   - DEF_MAX_BURST        : default bytes allowed under one grant
//   - DEF_START_TO         : default cycles allowed for tx_busy to rise
//   - state_e              : arbiter sequencing states
//   - onehot8_to_idx()     : index of the set bit in a one-hot vector (<= 8 bits)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_BYTE_W   = 8;
  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_START_TO  = 8;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARB        = 3'd1,
    S_LOAD       = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4
  } state_e;

  // Returns the position of the (single) set bit; 0 when no bit is set.
  function automatic logic [2:0] onehot8_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req upward starting at ptr and
// wrapping, and returns a one-hot vector for the first set request.
// Ports:
//   req  [N-1:0]   request vector
//   ptr  [PW-1:0]  index where the search starts (must be < N)
//   gnt  [N-1:0]   one-hot pick, all zero when req is zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART byte transmitter between N requesters. One requester owns
// the transmitter for a packet (ended by req_last, or cut at MAX_BURST bytes),
// then ownership passes round-robin to the next waiting requester.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid [N]     requester i has a byte pending
//   req_data  [8N]    byte of requester i at [8i+7:8i]
//   req_last  [N]     pending byte of requester i ends its packet
//   req_ready [N]     byte of requester i accepted this cycle
//   grant     [N]     one-hot owner, zero when nobody owns the transmitter
//   tx_send           one-cycle start pulse to the transmitter
//   tx_data   [8]     byte to transmit, held until the next load
//   tx_busy           transmitter is framing a byte
//   err_timeout       one-cycle pulse: tx_busy never rose after tx_send
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int START_TO  = DEF_START_TO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  input  logic [UART_BYTE_W*N-1:0] req_data,
  input  logic [N-1:0]             req_last,
  output logic [N-1:0]             req_ready,
  output logic [N-1:0]             grant,
  output logic                     tx_send,
  output logic [UART_BYTE_W-1:0]   tx_data,
  input  logic                     tx_busy,
  output logic                     err_timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(START_TO + 1);

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [N-1:0]           grant_q, grant_d;
  logic                   tx_send_q, tx_send_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   last_q, last_d;
  logic [BW-1:0]          burst_q, burst_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   err_q, err_d;

  logic [N-1:0]           arb_gnt;
  logic [7:0]             grant8;
  logic [PW-1:0]          g_idx;
  logic [PW-1:0]          ptr_next;
  logic                   any_valid;
  logic                   g_valid;
  logic [UART_BYTE_W-1:0] g_data;
  logic                   g_last;

  rr_arbiter #(.N(N)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Owner index and the pointer value that hands priority to its successor.
  always_comb begin
    grant8          = '0;
    grant8[N-1:0]   = grant_q;
    g_idx           = PW'(onehot8_to_idx(grant8));
    ptr_next        = PW'((int'(g_idx) + 1) % N);
  end

  assign any_valid = |req_valid;
  assign g_valid   = |(req_valid & grant_q);

  // Only the owner's lanes are looked at; other requesters are ignored.
  always_comb begin
    g_data = '0;
    g_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        g_data = req_data[UART_BYTE_W*i +: UART_BYTE_W];
        g_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_send_d = 1'b0;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    burst_d   = burst_q;
    to_d      = to_q;
    err_d     = 1'b0;
    req_ready = '0;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (any_valid) state_d = S_ARB;
      end

      S_ARB: begin
        burst_d = '0;
        if (any_valid) begin
          grant_d = arb_gnt;
          state_d = S_LOAD;
        end else begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        // Handshake is combinational so the byte moves on this very edge.
        req_ready = req_valid & grant_q;
        if (g_valid) begin
          tx_data_d = g_data;
          tx_send_d = 1'b1;
          last_d    = g_last;
          burst_d   = burst_q + BW'(1);
          to_d      = '0;
          state_d   = S_WAIT_START;
        end else begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = S_ARB;
        end
      end

      S_WAIT_START: begin
        // to_q counts the cycles already spent here, starting at the tx_send cycle.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == TW'(START_TO - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = S_ARB;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (!last_q && (burst_q < BW'(MAX_BURST)) && g_valid) begin
            state_d = S_LOAD;
          end else begin
            grant_d = '0;
            ptr_d   = ptr_next;
            state_d = any_valid ? S_ARB : S_IDLE;
          end
        end
      end

      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register: everything returns to its idle value at once on reset,
  // including tx_send so a half-issued start pulse is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      burst_q   <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      to_q      <= to_d;
      err_q     <= err_d;
    end
  end

  assign grant       = grant_q;
  assign tx_send     = tx_send_q;
  assign tx_data     = tx_data_q;
  assign err_timeout = err_q;

endmodule
